joypad_port_controller: RTL and testbench

- Sits between the PS/2 keyboard front end and the CPU bus decode. Serves the two NES controller registers at $4016 and $4017.
- Captures button bytes from up to two upstream receivers over a valid/ready handshake, keeping each player's state current.
- Emulates the NES controller strobe/latch/serial-read protocol that games use to poll input.
- Button byte layout, bit0..bit7: A, B, SELECT, START, UP, DOWN, LEFT, RIGHT.

---
 rtl/joypad_pkg.sv | 25 ++
 rtl/joypad_port_controller_if.sv | 24 ++
 rtl/joypad_shifter.sv | 86 ++++++++
 rtl/joypad_port_controller.sv | 91 +++++++++
 tb/tb_joypad_port_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/joypad_pkg.sv
// Shared constants, button layout and port FSM encoding for the NES joypad port controller.
package joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic ADDR_4016 = 1'b0;
    localparam logic ADDR_4017 = 1'b1;

    localparam int SHIFT_LEN = 8;
    localparam int COUNT_W   = 4;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        SHIFT     = 2'd1,
        EXHAUSTED = 2'd2
    } port_state_t;

endpackage

// File: rtl/joypad_port_controller_if.sv
// Bundles the upstream pad handshake and the CPU register bus of the joypad port controller.
interface joypad_port_controller_if;

    logic [15:0] pad_data_i;
    logic [1:0]  pad_valid_i;
    logic [1:0]  pad_ready_o;
    logic        cpu_addr_i;
    logic        cpu_wr_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_rd_i;
    logic [7:0]  cpu_rdata_o;
    logic        cpu_rdata_valid_o;

    modport master (
        output pad_data_i, pad_valid_i, cpu_addr_i, cpu_wr_i, cpu_wdata_i, cpu_rd_i,
        input  pad_ready_o, cpu_rdata_o, cpu_rdata_valid_o
    );

    modport slave (
        input  pad_data_i, pad_valid_i, cpu_addr_i, cpu_wr_i, cpu_wdata_i, cpu_rd_i,
        output pad_ready_o, cpu_rdata_o, cpu_rdata_valid_o
    );

endinterface

// File: rtl/joypad_shifter.sv
// One controller port: live button state, latched shift register, read count and LOAD/SHIFT/EXHAUSTED FSM.
module joypad_shifter
    import joypad_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_strobe_set,
    input  logic       i_strobe_clr,
    input  logic       i_capture,
    input  logic [7:0] i_capture_data,
    input  logic       i_rd,
    output logic       o_rd_bit
);

    logic [7:0]         r_pad_state;
    logic [7:0]         r_shift;
    logic [7:0]         w_next_shift;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_next_count;
    logic [COUNT_W-1:0] w_count_inc;
    port_state_t        r_state;
    port_state_t        w_next_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pad_state <= 8'h00;
        end else if (i_capture) begin
            r_pad_state <= i_capture_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SHIFT;
            r_shift <= 8'h00;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_shift <= w_next_shift;
            r_count <= w_next_count;
        end
    end

    assign w_count_inc = r_count + COUNT_W'(1);

    // The shift register always reloads from the pre-capture pad state, so a
    // capture in the strobe-clearing cycle cannot leak into the latched byte.
    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_count = r_count;
        o_rd_bit     = 1'b0;
        case (r_state)
            LOAD: begin
                w_next_shift = r_pad_state;
                w_next_count = '0;
                o_rd_bit     = r_pad_state[BTN_A];
                if (i_strobe_clr) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                o_rd_bit = r_shift[0];
                if (i_rd) begin
                    w_next_shift = {1'b1, r_shift[7:1]};
                    w_next_count = w_count_inc;
                    if (w_count_inc == COUNT_W'(SHIFT_LEN)) begin
                        w_next_state = EXHAUSTED;
                    end
                end
            end
            EXHAUSTED: begin
                o_rd_bit = 1'b1;
            end
            default: begin
                w_next_state = SHIFT;
            end
        endcase
        if (i_strobe_set) begin
            w_next_state = LOAD;
            w_next_shift = r_pad_state;
            w_next_count = '0;
        end
    end

endmodule

// File: rtl/joypad_port_controller.sv
// NES $4016/$4017 controller ports: strobe register, address decode, read data and upstream ready.
module joypad_port_controller
    import joypad_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS  = 8'h40,
    parameter bit         ENABLE_P2 = 1'b1
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    joypad_port_controller_if.slave  bus
);

    localparam logic P2_EN = ENABLE_P2 ? 1'b1 : 1'b0;

    logic       r_strobe;
    logic [1:0] r_ready;
    logic [7:0] r_rdata;
    logic       r_rdata_valid;

    logic       w_rd_ok;
    logic       w_wr_4016;
    logic       w_strobe_set;
    logic       w_strobe_clr;
    logic       w_sel_bit;
    logic [1:0] w_capture;
    logic [1:0] w_rd_port;
    logic [1:0] w_port_bit;

    // A write in the same cycle as a read takes priority and the read is lost.
    assign w_rd_ok      = bus.cpu_rd_i & ~bus.cpu_wr_i;
    assign w_wr_4016    = bus.cpu_wr_i & (bus.cpu_addr_i == ADDR_4016);
    assign w_strobe_set = w_wr_4016 & bus.cpu_wdata_i[0];
    assign w_strobe_clr = w_wr_4016 & ~bus.cpu_wdata_i[0] & r_strobe;

    assign w_capture    = bus.pad_valid_i & r_ready;
    assign w_rd_port[0] = w_rd_ok & (bus.cpu_addr_i == ADDR_4016);
    assign w_rd_port[1] = w_rd_ok & (bus.cpu_addr_i == ADDR_4017);

    assign w_sel_bit = (bus.cpu_addr_i == ADDR_4017) ? (w_port_bit[1] & P2_EN) : w_port_bit[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_strobe <= 1'b0;
            r_ready  <= 2'b00;
        end else begin
            r_ready <= {P2_EN, 1'b1};
            if (w_wr_4016) begin
                r_strobe <= bus.cpu_wdata_i[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata       <= 8'h00;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rdata <= {OPEN_BUS[7:1], w_sel_bit};
            end
        end
    end

    joypad_shifter u_port1 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_strobe_set   (w_strobe_set),
        .i_strobe_clr   (w_strobe_clr),
        .i_capture      (w_capture[0]),
        .i_capture_data (bus.pad_data_i[7:0]),
        .i_rd           (w_rd_port[0]),
        .o_rd_bit       (w_port_bit[0])
    );

    joypad_shifter u_port2 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .i_strobe_set   (w_strobe_set),
        .i_strobe_clr   (w_strobe_clr),
        .i_capture      (w_capture[1]),
        .i_capture_data (bus.pad_data_i[15:8]),
        .i_rd           (w_rd_port[1]),
        .o_rd_bit       (w_port_bit[1])
    );

    assign bus.pad_ready_o       = r_ready;
    assign bus.cpu_rdata_o       = r_rdata;
    assign bus.cpu_rdata_valid_o = r_rdata_valid;

endmodule

// File: tb/tb_joypad_port_controller.sv
// Self-checking bench: directed NES polling scenarios plus random traffic against a byte/index model,
// run on a two-player instance and a player-2-disabled instance in lockstep.
module tb_joypad_port_controller;
    import joypad_pkg::*;

    localparam logic [7:0] OPEN_BUS = 8'h40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    joypad_port_controller_if bus0 ();
    joypad_port_controller_if bus1 ();

    joypad_port_controller #(.OPEN_BUS(OPEN_BUS), .ENABLE_P2(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    joypad_port_controller #(.OPEN_BUS(OPEN_BUS), .ENABLE_P2(1'b0)) dutNoP2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Model: per instance, per port live byte, latched byte and how many bits have been read out.
    logic [7:0] mPad     [2][2];
    logic [7:0] mLatched [2][2];
    int         mIdx     [2][2];
    logic       mStrobe  [2];
    logic [1:0] mReady   [2];
    logic [7:0] mRdata   [2];
    logic       mValid   [2];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int inst = 0; inst < 2; inst++) begin
            for (int p = 0; p < 2; p++) begin
                mPad[inst][p]     = 8'h00;
                mLatched[inst][p] = 8'h00;
                mIdx[inst][p]     = 0;
            end
            mStrobe[inst] = 1'b0;
            mReady[inst]  = 2'b00;
            mRdata[inst]  = 8'h00;
            mValid[inst]  = 1'b0;
        end
    endtask

    task automatic modelStep(input logic wr, input logic rd, input logic addr, input logic [7:0] wdata,
                             input logic [1:0] valid, input logic [15:0] data);
        for (int inst = 0; inst < 2; inst++) begin
            bit   en;
            int   p;
            logic b;
            en = (inst == 0);
            mValid[inst] = rd && !wr;
            if (rd && !wr) begin
                p = int'(addr);
                if (p == 1 && !en) begin
                    b = 1'b0;
                end else if (mStrobe[inst]) begin
                    b = mPad[inst][p][0];
                end else if (mIdx[inst][p] < SHIFT_LEN) begin
                    b = mLatched[inst][p][mIdx[inst][p]];
                end else begin
                    b = 1'b1;
                end
                if (!mStrobe[inst] && mIdx[inst][p] < SHIFT_LEN) begin
                    mIdx[inst][p]++;
                end
                mRdata[inst] = {OPEN_BUS[7:1], b};
            end
            if (wr && addr == 1'b0) begin
                if (mStrobe[inst] && !wdata[0]) begin
                    for (int q = 0; q < 2; q++) begin
                        mLatched[inst][q] = mPad[inst][q];
                        mIdx[inst][q]     = 0;
                    end
                end
                mStrobe[inst] = wdata[0];
            end
            for (int q = 0; q < 2; q++) begin
                if (valid[q] && mReady[inst][q]) begin
                    mPad[inst][q] = data[q*8 +: 8];
                end
            end
            mReady[inst] = {en, 1'b1};
        end
    endtask

    task automatic checkAll();
        checkOutput("valid_p2on",  {15'd0, bus0.cpu_rdata_valid_o}, {15'd0, mValid[0]});
        checkOutput("rdata_p2on",  {8'd0, bus0.cpu_rdata_o},        {8'd0, mRdata[0]});
        checkOutput("ready_p2on",  {14'd0, bus0.pad_ready_o},       {14'd0, mReady[0]});
        checkOutput("valid_p2off", {15'd0, bus1.cpu_rdata_valid_o}, {15'd0, mValid[1]});
        checkOutput("rdata_p2off", {8'd0, bus1.cpu_rdata_o},        {8'd0, mRdata[1]});
        checkOutput("ready_p2off", {14'd0, bus1.pad_ready_o},       {14'd0, mReady[1]});
    endtask

    task automatic driveBus(input logic wr, input logic rd, input logic addr, input logic [7:0] wdata,
                            input logic [1:0] valid, input logic [15:0] data);
        bus0.cpu_wr_i = wr;   bus1.cpu_wr_i = wr;
        bus0.cpu_rd_i = rd;   bus1.cpu_rd_i = rd;
        bus0.cpu_addr_i = addr;   bus1.cpu_addr_i = addr;
        bus0.cpu_wdata_i = wdata; bus1.cpu_wdata_i = wdata;
        bus0.pad_valid_i = valid; bus1.pad_valid_i = valid;
        bus0.pad_data_i = data;   bus1.pad_data_i = data;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic addr, input logic [7:0] wdata,
                                 input logic [1:0] valid, input logic [15:0] data);
        @(negedge clk);
        driveBus(wr, rd, addr, wdata, valid, data);
        @(posedge clk);
        modelStep(wr, rd, addr, wdata, valid, data);
        #1;
        checkAll();
    endtask

    task automatic readPort(input logic addr, input logic [7:0] expected, input string tag);
        applyStimulus(1'b0, 1'b1, addr, 8'h00, 2'b00, 16'h0000);
        checkOutput(tag, {8'd0, bus0.cpu_rdata_o}, {8'd0, expected});
        checkOutput({tag, "_valid"}, {15'd0, bus0.cpu_rdata_valid_o}, 16'd1);
    endtask

    task automatic writeStrobe(input logic v);
        applyStimulus(1'b1, 1'b0, 1'b0, {7'd0, v}, 2'b00, 16'h0000);
    endtask

    task automatic capturePad(input int p, input logic [7:0] val);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, (p == 0) ? 2'b01 : 2'b10, (p == 0) ? {8'h00, val} : {val, 8'h00});
    endtask

    // A read is launched, then reset lands before the edge that would have completed it.
    task automatic applyReset();
        @(negedge clk);
        driveBus(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 16'h0000);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        checkOutput("in_reset_rdata", {8'd0, bus0.cpu_rdata_o}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("in_reset_valid", {15'd0, bus0.cpu_rdata_valid_o}, 16'h0000);
        @(negedge clk);
        driveBus(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        rst_n = 1'b1;
        #1;
        checkAll();
        checkOutput("ready_at_release", {14'd0, bus0.pad_ready_o}, 16'h0000);
    endtask

    initial begin
        bit [7:0] seq1 [10];
        seq1 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
        driveBus(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        modelReset();
        #1;
        checkAll();
        checkOutput("reset_ready", {14'd0, bus0.pad_ready_o}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        checkOutput("first_ready_p2on",  {14'd0, bus0.pad_ready_o}, 16'h0003);
        checkOutput("first_ready_p2off", {14'd0, bus1.pad_ready_o}, 16'h0001);

        $display("[TB] A+START serial read-out");
        capturePad(0, 8'h09);
        writeStrobe(1'b1);
        writeStrobe(1'b0);
        for (int i = 0; i < 10; i++) begin
            readPort(ADDR_4016, seq1[i], $sformatf("seq09_rd%0d", i));
        end

        $display("[TB] strobe held high returns live A");
        writeStrobe(1'b1);
        capturePad(0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            readPort(ADDR_4016, 8'h41, $sformatf("live_a_rd%0d", i));
        end
        capturePad(0, 8'h00);
        readPort(ADDR_4016, 8'h40, "live_a_cleared");
        writeStrobe(1'b0);

        $display("[TB] player 2 latch survives later capture");
        capturePad(1, 8'h80);
        writeStrobe(1'b1);
        writeStrobe(1'b0);
        for (int i = 0; i < 3; i++) readPort(ADDR_4017, 8'h40, $sformatf("p2_rd%0d", i));
        capturePad(1, 8'h00);
        readPort(ADDR_4016, 8'h40, "p1_interleave0");
        readPort(ADDR_4016, 8'h40, "p1_interleave1");
        for (int i = 3; i < 7; i++) readPort(ADDR_4017, 8'h40, $sformatf("p2_rd%0d", i));
        readPort(ADDR_4017, 8'h41, "p2_rd7_right");
        checkOutput("p2off_4017", {8'd0, bus1.cpu_rdata_o}, 16'h0040);

        $display("[TB] capture coincident with strobe clear");
        capturePad(0, 8'h01);
        writeStrobe(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 16'h0002);
        readPort(ADDR_4016, 8'h41, "coinc_bit0_old");
        readPort(ADDR_4016, 8'h40, "coinc_bit1_old");
        writeStrobe(1'b1);
        readPort(ADDR_4016, 8'h40, "coinc_live_new");
        writeStrobe(1'b0);
        readPort(ADDR_4016, 8'h40, "reload_bit0");
        readPort(ADDR_4016, 8'h41, "reload_bit1");

        $display("[TB] simultaneous read and write");
        capturePad(0, 8'h05);
        writeStrobe(1'b1);
        writeStrobe(1'b0);
        readPort(ADDR_4016, 8'h41, "rw_bit0");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 16'h0000);
        checkOutput("rw_drop_valid0", {15'd0, bus0.cpu_rdata_valid_o}, 16'd0);
        readPort(ADDR_4016, 8'h40, "rw_bit1_not_skipped");
        readPort(ADDR_4016, 8'h41, "rw_bit2");
        capturePad(0, 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 2'b00, 16'h0000);
        checkOutput("rw_drop_valid1", {15'd0, bus0.cpu_rdata_valid_o}, 16'd0);
        readPort(ADDR_4016, 8'h41, "rw_strobe_taken");

        $display("[TB] reset mid-sequence");
        capturePad(0, 8'h09);
        capturePad(1, 8'hff);
        writeStrobe(1'b1);
        writeStrobe(1'b0);
        readPort(ADDR_4016, 8'h41, "pre_rst0");
        readPort(ADDR_4016, 8'h40, "pre_rst1");
        readPort(ADDR_4016, 8'h40, "pre_rst2");
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        checkOutput("post_rst_ready_p2on",  {14'd0, bus0.pad_ready_o}, 16'h0003);
        checkOutput("post_rst_ready_p2off", {14'd0, bus1.pad_ready_o}, 16'h0001);
        writeStrobe(1'b1);
        readPort(ADDR_4016, 8'h40, "post_rst_pad_zero");
        capturePad(1, 8'h01);
        readPort(ADDR_4017, 8'h41, "post_rst_p2_live");
        checkOutput("p2off_read_zero", {8'd0, bus1.cpu_rdata_o}, 16'h0040);
        writeStrobe(1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            logic       wr;
            logic       rd;
            logic       addr;
            logic [7:0] wdata;
            logic [1:0] valid;
            logic [15:0] data;
            wr    = ($urandom_range(0, 7) == 0);
            rd    = ($urandom_range(0, 1) == 1);
            addr  = 1'($urandom_range(0, 1));
            wdata = 8'($urandom);
            valid = 2'($urandom_range(0, 3));
            data  = 16'($urandom);
            applyStimulus(wr, rd, addr, wdata, valid, data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
